seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 29 ++
 rtl/seg_scan_ctrl_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the four-digit seven-segment scan controller:
// digit count, blank pattern and the active-low hex-to-segment table.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry i is the active-low a..g pattern for hex digit i (listed F down to 0).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,
        7'b0110000,
        7'b1000010,
        7'b0110001,
        7'b1100000,
        7'b0001000,
        7'b0000100,
        7'b0000000,
        7'b0001111,
        7'b0100000,
        7'b0100100,
        7'b1001100,
        7'b0000110,
        7'b0010010,
        7'b1001111,
        7'b0000001
    };

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex digit to active-low seven-segment pattern (a = bit 6).
module seg7_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed four-digit seven-segment driver with frame-synchronous,
// tear-free updates of the displayed value.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lzb,
    input  logic        load,
    output logic        pending,
    output logic        frame_done,
    output logic [6:0]  a_to_g,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          wrap;

    logic [15:0]   act_data;
    logic [3:0]    act_dp;
    logic [3:0]    act_blank;
    logic [15:0]   pend_data;
    logic [3:0]    pend_dp;
    logic [3:0]    pend_blank;

    logic [3:0]    lz_blank;
    logic [3:0]    digit_blank;
    logic [3:0]    cur_hex;
    logic [6:0]    cur_seg;

    assign tick = (cnt == CNT_MAX);
    assign wrap = tick && (idx == 2'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // load is a one-cycle strobe with no ready: it is always accepted. Outside a
    // wrap it parks in the pending registers (last one wins) and pending stays high
    // until the next wrap moves it to the active set; a load on the wrap goes
    // straight to the active set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (wrap) begin
                pending <= 1'b0;
                if (load) begin
                    act_data  <= data_in;
                    act_dp    <= dp_in;
                    act_blank <= blank_in;
                end else if (pending) begin
                    act_data  <= pend_data;
                    act_dp    <= pend_dp;
                    act_blank <= pend_blank;
                end
            end else if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pending    <= 1'b1;
            end
        end
    end

    // Digit i (i >= 1) is a leading zero when it and every digit above it are zero.
    assign lz_blank = lzb ? {act_data[15:12] == 4'h0, act_data[15:8] == 8'h0,
                             act_data[15:4] == 12'h0, 1'b0} : 4'h0;
    assign digit_blank = act_blank | lz_blank;
    assign cur_hex = act_data[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an     <= 4'b1111;
            a_to_g <= SEG_BLANK;
            dp     <= 1'b1;
        end else if (digit_blank[idx]) begin
            an     <= 4'b1111;
            a_to_g <= SEG_BLANK;
            dp     <= 1'b1;
        end else begin
            an     <= ~(4'b0001 << idx);
            a_to_g <= cur_seg;
            dp     <= ~act_dp[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a time-based frame model.
module tb_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lzb;
    logic        load;
    logic        pending;
    logic        frame_done;
    logic [6:0]  a_to_g;
    logic        dp;
    logic [3:0]  an;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: cycle count since reset release plus shown/queued values
    int          m_t;
    logic [15:0] m_data, m_pdata;
    logic [3:0]  m_dp, m_pdp, m_blank, m_pblank;
    logic        m_pend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd, exp_pend;
    logic [6:0]  seg_ref [16];

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lzb        (lzb),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .a_to_g     (a_to_g),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {an, a_to_g, dp, frame_done, pending};
    endfunction

    function automatic logic [13:0] expv();
        return {exp_an, exp_seg, exp_dp, exp_fd, exp_pend};
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_data = '0; m_dp = '0; m_blank = '0;
        m_pdata = '0; m_pdp = '0; m_pblank = '0;
        m_pend = 1'b0;
    endtask

    // One clock: predict what the DUT shows after this edge, then take the edge.
    task automatic step();
        int         slot;
        logic [3:0] nib;
        logic       blanked;
        slot    = (m_t / DIV) % 4;
        nib     = 4'(m_data >> (4 * slot));
        blanked = m_blank[slot] || (lzb && slot >= 1 && (m_data >> (4 * slot)) == 16'h0);
        if (blanked) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            exp_an = 4'hF; exp_an[slot] = 1'b0;
            exp_seg = seg_ref[nib];
            exp_dp = ~m_dp[slot];
        end
        exp_fd = (m_t % FRAME) == FRAME - 1;
        if (exp_fd) begin
            if (load) begin
                m_data = data_in; m_dp = dp_in; m_blank = blank_in;
            end else if (m_pend) begin
                m_data = m_pdata; m_dp = m_pdp; m_blank = m_pblank;
            end
            m_pend = 1'b0;
        end else if (load) begin
            m_pdata = data_in; m_pdp = dp_in; m_pblank = blank_in;
            m_pend = 1'b1;
        end
        exp_pend = m_pend;
        m_t++;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic align(input int k);
        while (m_t % FRAME != k) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF; blank_in = 4'h0; lzb = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({an, a_to_g, dp, frame_done, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got %b required %b", obs(), {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        model_reset();
        step();
        n_vec++;
        if (an !== 4'b1110 || a_to_g !== 7'b0000001 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL first_after_reset: an=%b seg=%b pend=%b required an=1110 seg=0000001 pend=0",
                     an, a_to_g, pending);
        end
    endtask

    task automatic test_idle_scan();
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL idle_scan t=%0d: got %b required %b", m_t, obs(), expv());
            end
        end
    endtask

    task automatic test_load_mid_frame();
        align($urandom_range(3, 10));
        data_in = 16'h1234; dp_in = 4'b0010; blank_in = 4'h0; load = 1'b1;
        step();
        n_vec++;
        if (pending !== 1'b1) begin
            n_err++;
            $display("FAIL mid_load_pending: got %b required 1", pending);
        end
        align(FRAME - 1);
        step();
        n_vec++;
        if (frame_done !== 1'b1 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL mid_load_wrap: fd=%b pend=%b required fd=1 pend=0", frame_done, pending);
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL mid_load_frame t=%0d: got %b required %b", m_t, obs(), expv());
            end
            if (i == 0 || i == DIV) begin
                n_vec++;
                if ((i == 0 && {an, a_to_g} !== {4'b1110, 7'b1001100}) ||
                    (i == DIV && {an, a_to_g, dp} !== {4'b1101, 7'b0000110, 1'b0})) begin
                    n_err++;
                    $display("FAIL mid_load_digit slot=%0d: an=%b seg=%b dp=%b", i / DIV, an, a_to_g, dp);
                end
            end
        end
    endtask

    task automatic test_last_wins();
        lzb = 1'b1;
        align(2);
        data_in = 16'h00A5; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1;
        step();
        step();
        data_in = 16'h0007; load = 1'b1;
        step();
        align(FRAME - 1);
        step();
        for (int i = 0; i < FRAME; i++) begin
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL last_wins t=%0d: got %b required %b", m_t, obs(), expv());
            end
            if (i % DIV == 1) begin
                n_vec++;
                if ((i / DIV == 0 && {an, a_to_g} !== {4'b1110, 7'b0001111}) ||
                    (i / DIV != 0 && {an, a_to_g} !== {4'b1111, 7'b1111111})) begin
                    n_err++;
                    $display("FAIL last_wins_lzb slot=%0d: an=%b seg=%b", i / DIV, an, a_to_g);
                end
            end
        end
        lzb = 1'b0;
    endtask

    task automatic test_load_on_wrap();
        align(FRAME - 1);
        data_in = 16'hBEEF; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1;
        step();
        for (int i = 0; i <= FRAME; i++) begin
            n_vec++;
            if (pending !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_load_pending i=%0d: got %b required 0", i, pending);
            end
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL wrap_load t=%0d: got %b required %b", m_t, obs(), expv());
            end
            if (i == 0 || i == 3 * DIV) begin
                n_vec++;
                if ((i == 0 && {an, a_to_g} !== {4'b1110, 7'b0111000}) ||
                    (i != 0 && {an, a_to_g} !== {4'b0111, 7'b1100000})) begin
                    n_err++;
                    $display("FAIL wrap_load_digit i=%0d: an=%b seg=%b", i, an, a_to_g);
                end
            end
        end
    endtask

    task automatic test_force_blank();
        align(5);
        data_in = 16'h8888; dp_in = 4'h0; blank_in = 4'b0100; load = 1'b1;
        step();
        align(FRAME - 1);
        step();
        for (int i = 0; i < FRAME; i++) begin
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL force_blank t=%0d: got %b required %b", m_t, obs(), expv());
            end
            if (i % DIV == 2) begin
                n_vec++;
                if ((i / DIV == 2 && {an, a_to_g} !== {4'b1111, 7'b1111111}) ||
                    (i / DIV != 2 && a_to_g !== 7'b0000000)) begin
                    n_err++;
                    $display("FAIL force_blank_digit slot=%0d: an=%b seg=%b", i / DIV, an, a_to_g);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 480; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                data_in  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
                dp_in    = 4'($urandom_range(0, 15));
                blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                load     = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) lzb = ~lzb;
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL random t=%0d: got %b required %b", m_t, obs(), expv());
            end
        end
        lzb = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        align(4);
        data_in = 16'h4321; dp_in = 4'hF; blank_in = 4'h0; load = 1'b1;
        step();
        step();
        n_vec++;
        if (pending !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_pending: got %b required 1", pending);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({an, a_to_g, dp, frame_done, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got %b required %b", obs(), {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL after_reset t=%0d: got %b required %b", m_t, obs(), expv());
            end
        end
    endtask

    initial begin
        seg_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        model_reset();
        test_reset();
        test_idle_scan();
        test_load_mid_frame();
        test_last_wins();
        test_load_on_wrap();
        test_force_blank();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
